ps2_frame_receiver: RTL and testbench
=====================================

// Module: ps2_frame_receiver
// PURPOSE
//  Receive-only PS/2 device-to-host deserializer feeding the keyboard scan-code decoder.
//  Synchronizes and glitch-filters PS2_CLK and samples PS2_DATA on filtered falling edges.
//  Checks each 11-bit frame (start, 8 data LSB-first, odd parity, stop) and reports good bytes.
//  Flags E0/F0 prefixes separately; emits single-cycle err on bad frames.
// PARAMETERS
//  FILTER_LEN   8        consecutive equal synced samples needed before filtered clock changes (>=2)
//  TIMEOUT_CYC  100000   max clock cycles between filtered falling edges inside a frame (PS2_TIMEOUT_EN)
// PORTS
//  clock      in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  ps2_clk    in   1  raw PS/2 clock pin (asynchronous)
//  ps2_data   in   1  raw PS/2 data pin (asynchronous)
//  key_in     out  8  last good non-prefix byte; held until the next one
//  valid      out  1  1-cycle pulse: key_in just updated
//  is_extend  out  1  1-cycle pulse: good E0 byte received
//  is_break   out  1  1-cycle pulse: good F0 byte received
//  err        out  1  1-cycle pulse: frame discarded (parity/stop error or timeout)
// BEHAVIOUR
//  Reset: all outputs 0, key_in 8'h00, FSM IDLE, sync regs and filtered clock 1, counters 0.
//  Sync: 2-FF synchronizer on each pin. Filter: run counter of consecutive synced-clock samples
//   differing from filtered level; filtered level flips when FILTER_LEN differing samples in a row.
//  fall = registered 1-cycle strobe on filtered 1->0 transition; data sampled from synced ps2_data.
//  FSM (advances only on fall):
//   IDLE: data==0 -> DATA, bitcnt=0; data==1 -> stay (spurious edge ignored, no err).
//   DATA: shift[bitcnt]<=data (LSB first); bitcnt==7 -> PARITY else bitcnt+1 (3-bit, no wrap).
//   PARITY: capture p; -> STOP.
//   STOP: -> IDLE; good = (data==1) && (^shift ^ p)==1 (odd parity).
//  Output on the cycle after the STOP fall strobe (latency 1 clock from strobe):
//   good & byte==E0 -> is_extend=1; key_in, valid unchanged.
//   good & byte==F0 -> is_break=1; key_in, valid unchanged.
//   good other (incl. AA, FA) -> key_in<=byte, valid=1.
//   not good -> err=1; key_in unchanged, no other pulse.
//  At most one of valid/is_extend/is_break/err high in any cycle; all pulses exactly 1 cycle.
//  Back-to-back frames: next start bit accepted on the first fall after returning to IDLE.
//  rst mid-frame: frame aborted, no pulse, state as reset; reset release during low ps2_clk
//   produces no fall until a full high->low transition is filtered.
//  Glitches shorter than FILTER_LEN cycles on ps2_clk never produce a fall.
// CONFIGURATION
//  PS2_TIMEOUT_EN defined: cycle counter cleared on every fall and in IDLE, increments otherwise;
//   when it reaches TIMEOUT_CYC-1 outside IDLE -> IDLE, err pulse 1 cycle, partial byte dropped.
//  PS2_TIMEOUT_EN undefined: no counter; FSM waits indefinitely mid-frame for further edges.
// TESTING
//  Frame 0x1C, parity 0, stop 1, 30 us bit period -> key_in=8'h1C, valid 1 cycle, err=0.
//  Frames E0,F0,75 -> is_extend, then is_break, then valid with key_in=8'h75; key_in stays 8'h1C until 75.
//  Frame 0x1C with parity 1 -> err 1 cycle, valid=0, key_in unchanged.
//  Frame 0x29 with stop bit 0 -> err 1 cycle; next good frame 0x29 -> valid, key_in=8'h29.
//  3-cycle low glitch on ps2_clk in IDLE and mid-frame -> no bit sampled, byte decodes correctly.
//  PS2_TIMEOUT_EN, stop after 4 data bits -> err after TIMEOUT_CYC cycles; next full frame 0x5A -> valid.

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: sync, glitch filter, 11-bit frame check.
// Define PS2_TIMEOUT_EN to abort frames stalled longer than TIMEOUT_CYC cycles.
module ps2_frame_receiver #(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_in,
   output logic       valid,
   output logic       is_extend,
   output logic       is_break,
   output logic       err
);

   localparam int unsigned ARM_LEN = FILTER_LEN + 2;
   localparam int unsigned RW      = $clog2(ARM_LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic          filt_q, filt_d;
   logic          arm_q, arm_d;
   logic [RW-1:0] run_q, run_d;
   logic          fall_q, fall_d;

   state_t        state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [7:0]    key_q, key_d;
   logic          valid_q, valid_d;
   logic          ext_q, ext_d;
   logic          brk_q, brk_d;
   logic          err_q, err_d;
   logic          good;
   logic          to_hit;

   // After reset the pin level is unknown: a full filtered high must be
   // seen before any falling edge is allowed out of the filter.
   always_comb begin
      clk_s1_d = ps2_clk;
      clk_s2_d = clk_s1_q;
      dat_s1_d = ps2_data;
      dat_s2_d = dat_s1_q;
      run_d    = '0;
      filt_d   = filt_q;
      arm_d    = arm_q;
      if (!arm_q) begin
         if (clk_s2_q) begin
            if (run_q == RW'(ARM_LEN - 1)) begin
               arm_d = 1'b1;
            end else begin
               run_d = run_q + 1'b1;
            end
         end
      end else if (clk_s2_q != filt_q) begin
         if (run_q == RW'(FILTER_LEN - 1)) begin
            filt_d = clk_s2_q;
         end else begin
            run_d = run_q + 1'b1;
         end
      end
      fall_d = filt_q & ~filt_d;
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         arm_q    <= 1'b0;
         run_q    <= '0;
         fall_q   <= 1'b0;
      end else begin
         clk_s1_q <= clk_s1_d;
         clk_s2_q <= clk_s2_d;
         dat_s1_q <= dat_s1_d;
         dat_s2_q <= dat_s2_d;
         filt_q   <= filt_d;
         arm_q    <= arm_d;
         run_q    <= run_d;
         fall_q   <= fall_d;
      end
   end

`ifdef PS2_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);

   logic [TW-1:0] to_q, to_d;

   assign to_hit = (state_q != IDLE) && !fall_q &&
                   (to_q == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      to_d = to_q + 1'b1;
      if (fall_q || state_q == IDLE || to_hit) begin
         to_d = '0;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
   assign to_hit             = 1'b0;
`endif

   assign good = dat_s2_q & ((^shift_q) ^ par_q);

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      key_d   = key_q;
      valid_d = 1'b0;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      err_d   = 1'b0;
      if (fall_q) begin
         unique case (state_q)
            IDLE: begin
               if (!dat_s2_q) begin
                  state_d = DATA;
                  bit_d   = 3'd0;
               end
            end
            DATA: begin
               shift_d[bit_q] = dat_s2_q;
               if (bit_q == 3'd7) begin
                  state_d = PARITY;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
            PARITY: begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!good) begin
                  err_d = 1'b1;
               end else if (shift_q == 8'hE0) begin
                  ext_d = 1'b1;
               end else if (shift_q == 8'hF0) begin
                  brk_d = 1'b1;
               end else begin
                  key_d   = shift_q;
                  valid_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (to_hit) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         par_q   <= 1'b0;
         key_q   <= 8'h00;
         valid_q <= 1'b0;
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         key_q   <= key_d;
         valid_q <= valid_d;
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         err_q   <= err_d;
      end
   end

   assign key_in    = key_q;
   assign valid     = valid_q;
   assign is_extend = ext_q;
   assign is_break  = brk_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: directed PS/2 frames, queued
// expected events, monitor pops one entry per output pulse.
`timescale 1ns/1ps
module tb_ps2_frame_receiver;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] key;
   } ev_t;

   logic       clock = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] key_in;
   logic       valid, is_extend, is_break, err;

   ev_t        exp_q[$];
   logic [7:0] exp_key = 8'h00;
   int         checks  = 0;
   int         passes  = 0;

   ps2_frame_receiver #(
      .FILTER_LEN (8),
      .TIMEOUT_CYC(200)
   ) dut (
      .clock    (clock),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .key_in   (key_in),
      .valid    (valid),
      .is_extend(is_extend),
      .is_break (is_break),
      .err      (err)
   );

   always #250 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b,
                                      input logic bad_par,
                                      input logic stop);
      logic p;
      p = ~(^b) ^ bad_par;
      return {stop, p, b, 1'b0};
   endfunction

   // 60-cycle (30 us) bit cell; optional 3-cycle low glitch in the high phase
   task automatic send(input logic [10:0] f, input int nbits, input int gl);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         cyc(10);
         if (i == gl) begin
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(7);
         end else begin
            cyc(10);
         end
         ps2_clk = 1'b0;
         cyc(30);
         ps2_clk = 1'b1;
         cyc(10);
      end
      ps2_data = 1'b1;
   endtask

   task automatic exp_ok(input logic [7:0] b);
      exp_q.push_back({2'd0, b});
      exp_key = b;
   endtask

   task automatic exp_ev(input logic [1:0] k);
      exp_q.push_back({k, exp_key});
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (!rst && (valid | is_extend | is_break | err)) begin
            int   n;
            ev_t  got;
            ev_t  e;
            n = int'(valid) + int'(is_extend) + int'(is_break) + int'(err);
            got.kind = valid ? 2'd0 : is_extend ? 2'd1 : is_break ? 2'd2 : 2'd3;
            got.key  = key_in;
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_pulse: got kind %0d key %0h, none expected",
                        got.kind, got.key);
            end else begin
               e = exp_q.pop_front();
               if (n != 1)
                  $display("FAIL onehot: %0d pulses high, required 1", n);
               else if (got !== e)
                  $display("FAIL event: got kind %0d key %0h, expected kind %0d key %0h",
                           got.kind, got.key, e.kind, e.key);
               else
                  passes++;
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      ps2_clk  = 1'b0;
      ps2_data = 1'b0;
      cyc(5);
      chk("rst_key_in", 32'(key_in), 32'h00);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_is_extend", 32'(is_extend), 32'h0);
      chk("rst_is_break", 32'(is_break), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      rst = 1'b0;
      cyc(40);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      cyc(40);

      exp_ok(8'h1C);
      send(mk(8'h1C, 1'b0, 1'b1), 11, -1);
      cyc(20);

      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(20);

      exp_ev(2'd1);
      send(mk(8'hE0, 1'b0, 1'b1), 11, -1);
      exp_ev(2'd2);
      send(mk(8'hF0, 1'b0, 1'b1), 11, -1);
      exp_ok(8'h75);
      send(mk(8'h75, 1'b0, 1'b1), 11, 4);
      cyc(20);
      chk("hold_key_75", 32'(key_in), 32'h75);

      exp_ev(2'd3);
      send(mk(8'h1C, 1'b1, 1'b1), 11, -1);
      exp_ev(2'd3);
      send(mk(8'h29, 1'b0, 1'b0), 11, -1);
      exp_ok(8'h29);
      send(mk(8'h29, 1'b0, 1'b1), 11, -1);
      exp_ok(8'hAA);
      send(mk(8'hAA, 1'b0, 1'b1), 11, -1);
      exp_ok(8'hFA);
      send(mk(8'hFA, 1'b0, 1'b1), 11, -1);
      cyc(20);

      send(mk(8'h33, 1'b0, 1'b1), 5, -1);
      rst = 1'b1;
      cyc(3);
      chk("midrst_key_in", 32'(key_in), 32'h00);
      chk("midrst_valid", 32'(valid), 32'h0);
      chk("midrst_err", 32'(err), 32'h0);
      rst     = 1'b0;
      exp_key = 8'h00;
      cyc(30);
      exp_ok(8'h5A);
      send(mk(8'h5A, 1'b0, 1'b1), 11, -1);
      cyc(20);

`ifdef PS2_TIMEOUT_EN
      exp_ev(2'd3);
      send(mk(8'h6C, 1'b0, 1'b1), 5, -1);
      cyc(300);
      exp_ok(8'h5A);
      send(mk(8'h5A, 1'b0, 1'b1), 11, -1);
      cyc(20);
`endif

      cyc(100);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
